// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants for the register-file write arbiter: default geometry,
// FSM state encodings and requester identifiers.
package regfile_write_arbiter_pkg;

  localparam int DEF_NUM_REGS   = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;

  // FSM encodings
  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_ARB   = 1'b1;

  // Requester identifiers, also used as the priority token value
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef logic req_id_t;

  // The requester that gets priority after the given one has been served.
  function automatic req_id_t other_req(input req_id_t served);
    return (served == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the two writeback request channels and the register-file
// write-port outputs. master = requester/regfile side, slave = arbiter.
interface regfile_write_arbiter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  AValid;
  logic                  AReady;
  logic [ADDR_WIDTH-1:0] AAddr;
  logic [DATA_WIDTH-1:0] AData;
  logic                  BValid;
  logic                  BReady;
  logic [ADDR_WIDTH-1:0] BAddr;
  logic [DATA_WIDTH-1:0] BData;
  logic                  RegWrite;
  logic [ADDR_WIDTH-1:0] WriteRegister;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  ClearDone;

  modport master (
    output AValid, AAddr, AData, BValid, BAddr, BData,
    input  AReady, BReady, RegWrite, WriteRegister, WriteData, ClearDone
  );

  modport slave (
    input  AValid, AAddr, AData, BValid, BAddr, BData,
    output AReady, BReady, RegWrite, WriteRegister, WriteData, ClearDone
  );
endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-way combinational grant. A lone valid requester wins; when both are
// valid the one named by prio wins. Nothing is granted while disabled.
module rr_arbiter2
  import regfile_write_arbiter_pkg::*;
(
  input  logic valid_a,
  input  logic valid_b,
  input  logic prio,
  input  logic enable,
  output logic grant_a,
  output logic grant_b
);

  // Grant decision; grants are mutually exclusive by construction
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (enable) begin
      if (valid_a && (!valid_b || prio == REQ_A)) begin
        grant_a = 1'b1;
      end else if (valid_b) begin
        grant_b = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port owner. After reset it zeroes registers
// 1..NUM_REGS-1, then shares the port between requesters A and B with
// round-robin priority. Writes to register 0 are accepted and dropped.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_CLEAR | issuing one zero write per cycle, no grants
//   ST_ARB   | arbitrating A/B, one write per cycle at most
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RR_INIT    = 0
) (
  input  logic Clk,
  input  logic ResetN,
  regfile_write_arbiter_if.slave bus
);

  // The clear counter runs one past the last register so that the
  // completion cycle is distinguishable from the final zero write.
  localparam logic [ADDR_WIDTH:0] CLR_START = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] CLR_END   = (ADDR_WIDTH+1)'(NUM_REGS);
  localparam logic                PRIO_INIT = (RR_INIT != 0) ? REQ_B : REQ_A;

  logic                  state;
  logic [ADDR_WIDTH:0]   clr_cnt;
  logic                  prio;
  logic                  enable;
  logic                  grant_a;
  logic                  grant_b;
  logic                  reg_write;
  logic [ADDR_WIDTH-1:0] write_register;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  clear_done;

  // Grants are held off during reset as well, so a request pending when
  // ResetN drops is never reported accepted on the edge that cancels it.
  assign enable = (state == ST_ARB) && ResetN;

  rr_arbiter2 u_arb (
    .valid_a (bus.AValid),
    .valid_b (bus.BValid),
    .prio    (prio),
    .enable  (enable),
    .grant_a (grant_a),
    .grant_b (grant_b)
  );

  assign bus.AReady        = grant_a;
  assign bus.BReady        = grant_b;
  assign bus.RegWrite      = reg_write;
  assign bus.WriteRegister = write_register;
  assign bus.WriteData     = write_data;
  assign bus.ClearDone     = clear_done;

  // FSM, clear sequencing, priority token and registered write port
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      state          <= ST_CLEAR;
      clr_cnt        <= CLR_START;
      prio           <= PRIO_INIT;
      reg_write      <= 1'b0;
      write_register <= '0;
      write_data     <= '0;
      clear_done     <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_cnt == CLR_END) begin
            reg_write  <= 1'b0;
            clear_done <= 1'b1;
            state      <= ST_ARB;
          end else begin
            reg_write      <= 1'b1;
            write_register <= clr_cnt[ADDR_WIDTH-1:0];
            write_data     <= '0;
            clr_cnt        <= clr_cnt + 1'b1;
          end
        end
        default: begin
          reg_write <= 1'b0;
          if (grant_a) begin
            prio <= other_req(REQ_A);
            if (bus.AAddr != '0) begin
              reg_write      <= 1'b1;
              write_register <= bus.AAddr;
              write_data     <= bus.AData;
            end
          end else if (grant_b) begin
            prio <= other_req(REQ_B);
            if (bus.BAddr != '0) begin
              reg_write      <= 1'b1;
              write_register <= bus.BAddr;
              write_data     <= bus.BData;
            end
          end
        end
      endcase
    end
  end

endmodule
